// File: rtl/de_sweep_sequencer.sv
// rtl/de_sweep_sequencer.sv - steps the Difference Engine over n_first..n_last and paces results to the display
// Optional WAIT watchdog is built when DE_SEQ_TIMEOUT_EN is defined.
module de_sweep_sequencer #(
  parameter int N_W            = 6,
  parameter int DATA_W         = 13,
  parameter int DWELL_CYCLES   = 50_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              abort,
  input  logic [N_W-1:0]    n_first,
  input  logic [N_W-1:0]    n_last,
  output logic [N_W-1:0]    de_n,
  output logic              de_start,
  input  logic [DATA_W-1:0] de_data,
  input  logic              de_done_tick,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              busy,
  output logic              done_tick,
  output logic              err
);

  // One counter serves DWELL and the WAIT watchdog; the two states never overlap.
  localparam int CNT_MAX = (DWELL_CYCLES > TIMEOUT_CYCLES) ? DWELL_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [1:0] {IDLE, START, WAIT, DWELL} state_t;

  state_t           state;
  logic [N_W-1:0]   n_last_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      n_last_q   <= '0;
      cnt        <= '0;
      de_n       <= '0;
      de_start   <= 1'b0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      busy       <= 1'b0;
      done_tick  <= 1'b0;
      err        <= 1'b0;
    end else begin
      de_start  <= 1'b0;
      done_tick <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (go) begin
              n_last_q   <= n_last;
              err        <= 1'b0;
              disp_valid <= 1'b0;
              if (n_first <= n_last) begin
                de_n     <= n_first;
                de_start <= 1'b1;
                busy     <= 1'b1;
                state    <= START;
              end else begin
                err       <= 1'b1;
                done_tick <= 1'b1;
              end
            end
          end
          START: begin
            cnt   <= '0;
            state <= WAIT;
          end
          WAIT: begin
            if (de_done_tick) begin
              disp_data  <= de_data;
              disp_valid <= 1'b1;
              cnt        <= '0;
              state      <= DWELL;
            end
`ifdef DE_SEQ_TIMEOUT_EN
            else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              err       <= 1'b1;
              done_tick <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
`endif
          end
          DWELL: begin
            if (cnt == CNT_W'(DWELL_CYCLES - 1)) begin
              // Equality test before increment keeps n_last = max from wrapping.
              if (de_n == n_last_q) begin
                done_tick <= 1'b1;
                busy      <= 1'b0;
                state     <= IDLE;
              end else begin
                de_n     <= de_n + 1'b1;
                de_start <= 1'b1;
                state    <= START;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_de_sweep_sequencer.sv
// tb/tb_de_sweep_sequencer.sv - scoreboard bench for de_sweep_sequencer with a fixed-latency engine model
module tb_de_sweep_sequencer;

  localparam int N_W = 6;
  localparam int DATA_W = 13;
  localparam int LAT = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              go = 1'b0;
  logic              abort = 1'b0;
  logic [N_W-1:0]    n_first = '0;
  logic [N_W-1:0]    n_last = '0;
  logic [N_W-1:0]    de_n;
  logic              de_start;
  wire  [DATA_W-1:0] de_data;
  wire               de_done_tick;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              busy;
  logic              done_tick;
  logic              err;

  logic              eng_en = 1'b1;
  logic              eng_tick = 1'b0;
  logic [DATA_W-1:0] eng_data = '0;
  int                eng_cnt = 0;
  logic [N_W-1:0]    eng_n = '0;
  logic              stray_tick = 1'b0;
  logic [DATA_W-1:0] stray_data = '0;

  assign de_done_tick = eng_tick | stray_tick;
  assign de_data      = stray_tick ? stray_data : eng_data;

  de_sweep_sequencer #(
    .N_W(N_W), .DATA_W(DATA_W), .DWELL_CYCLES(4), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .abort(abort),
    .n_first(n_first), .n_last(n_last), .de_n(de_n), .de_start(de_start),
    .de_data(de_data), .de_done_tick(de_done_tick), .disp_data(disp_data),
    .disp_valid(disp_valid), .busy(busy), .done_tick(done_tick), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                n;
    bit                chk_disp;
    logic [DATA_W-1:0] d;
    logic              v;
  } start_t;
  typedef struct {
    logic              e;
    logic [DATA_W-1:0] d;
    logic              v;
  } done_t;

  start_t exp_start[$];
  done_t  exp_done[$];
  int     n_checks = 0;
  int     n_fail = 0;

  function automatic logic [DATA_W-1:0] model(input int n);
    return DATA_W'(n * n + 3 * n + 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Engine model: fixed latency from de_start to a one-cycle done tick.
  always @(negedge clk) begin
    eng_tick = 1'b0;
    if (!reset) begin
      eng_cnt = 0;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_tick = 1'b1;
          eng_data = model(int'(eng_n));
        end
      end
      if (de_start && eng_en) begin
        eng_cnt = LAT;
        eng_n   = de_n;
      end
    end
  end

  always @(negedge clk) begin
    start_t s;
    done_t  d;
    if (reset) begin
      if (de_start) begin
        if (exp_start.size() == 0) begin
          check("unexpected_de_start_n", de_n, 32'hFFFF_FFFF);
        end else begin
          s = exp_start.pop_front();
          check("de_n", de_n, s.n);
          if (s.chk_disp) begin
            check("disp_data_at_start", disp_data, s.d);
            check("disp_valid_at_start", disp_valid, s.v);
          end
        end
      end
      if (done_tick) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done_tick", done_tick, 0);
        end else begin
          d = exp_done.pop_front();
          check("done_err", err, d.e);
          check("done_disp_data", disp_data, d.d);
          check("done_disp_valid", disp_valid, d.v);
          check("done_busy", busy, 0);
        end
      end
    end
  end

  task automatic pulse_go(input int nf, input int nl);
    @(negedge clk);
    go = 1'b1; n_first = N_W'(nf); n_last = N_W'(nl);
    @(negedge clk);
    go = 1'b0;
  endtask

  // which: 0 = de_start seen, 1 = busy low, 2 = disp_valid high
  task automatic wait_for(input int which, input int limit, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = de_start;
        1: hit = !busy;
        default: hit = disp_valid;
      endcase
    end
    if (!hit) check({"timeout_", name}, 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_de_start", de_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done_tick", done_tick, 0);
    check("rst_err", err, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_disp_data", disp_data, 0);
    check("rst_de_n", de_n, 0);
    reset = 1'b1;

    // Basic sweep 2..4
    exp_start.push_back('{2, 1'b0, '0, 1'b0});
    exp_start.push_back('{3, 1'b1, model(2), 1'b1});
    exp_start.push_back('{4, 1'b1, model(3), 1'b1});
    exp_done.push_back('{1'b0, model(4), 1'b1});
    pulse_go(2, 4);
    check("busy_after_go", busy, 1);
    wait_for(1, 300, "sweep_2_4");

    // Top of range 62..63
    exp_start.push_back('{62, 1'b0, '0, 1'b0});
    exp_start.push_back('{63, 1'b1, model(62), 1'b1});
    exp_done.push_back('{1'b0, model(63), 1'b1});
    pulse_go(62, 63);
    wait_for(1, 300, "sweep_62_63");
    repeat (5) @(negedge clk);

    // Range error
    exp_done.push_back('{1'b1, model(63), 1'b0});
    pulse_go(9, 3);
    check("range_err", err, 1);
    check("range_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("range_busy_later", busy, 0);

    // Abort in WAIT coinciding with a done tick
    exp_start.push_back('{5, 1'b0, '0, 1'b0});
    exp_start.push_back('{6, 1'b1, model(5), 1'b1});
    pulse_go(5, 6);
    check("go_clears_err", err, 0);
    wait_for(2, 100, "abort_first_result");
    eng_en = 1'b0;
    wait_for(0, 100, "abort_second_start");
    repeat (3) @(negedge clk);
    abort = 1'b1; stray_tick = 1'b1; stray_data = 13'h1ABC;
    @(negedge clk);
    abort = 1'b0; stray_tick = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_disp_data", disp_data, model(5));
    check("abort_disp_valid", disp_valid, 1);
    check("abort_err", err, 0);
    repeat (3) @(negedge clk);
    eng_en = 1'b1;

    // Stray tick and go during DWELL, then reset mid-DWELL
    exp_start.push_back('{7, 1'b0, '0, 1'b0});
    pulse_go(7, 8);
    check("go_clears_disp_valid", disp_valid, 0);
    wait_for(2, 100, "dwell_entry");
    stray_tick = 1'b1; stray_data = 13'h0555;
    go = 1'b1; n_first = 6'd1; n_last = 6'd1;
    @(negedge clk);
    stray_tick = 1'b0; go = 1'b0;
    check("stray_disp_data", disp_data, model(7));
    check("stray_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_disp_valid", disp_valid, 0);
    check("async_rst_disp_data", disp_data, 0);
    check("async_rst_de_n", de_n, 0);
    check("async_rst_de_start", de_start, 0);
    check("async_rst_err", err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Engine never responds
    eng_en = 1'b0;
    exp_start.push_back('{10, 1'b0, '0, 1'b0});
`ifdef DE_SEQ_TIMEOUT_EN
    exp_done.push_back('{1'b1, '0, 1'b0});
    pulse_go(10, 10);
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (i == 21) check("timeout_done_tick", done_tick, 1);
      else if (done_tick) check("timeout_early", i, 21);
    end
    check("timeout_err", err, 1);
`else
    pulse_go(10, 10);
    repeat (40) @(negedge clk);
    check("no_watchdog_busy", busy, 1);
    check("no_watchdog_err", err, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("no_watchdog_abort", busy, 0);
`endif
    repeat (3) @(negedge clk);
    check("start_queue_empty", exp_start.size(), 0);
    check("done_queue_empty", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
